// File: rtl/ps2_pkg.sv
// Shared types, byte constants and the optional ASCII lookup for the PS/2 scan-code processor.
// The lookup function exists only when PS2_ASCII_EN is defined.
package ps2_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_EXT,
    ST_BRK,
    ST_EXT_BRK,
    ST_SKIP
  } ps2_state_t;

  localparam logic [7:0] CODE_E0 = 8'hE0;
  localparam logic [7:0] CODE_F0 = 8'hF0;
  localparam logic [7:0] CODE_E1 = 8'hE1;
  localparam logic [7:0] CODE_00 = 8'h00;
  localparam logic [7:0] CODE_AA = 8'hAA;
  localparam logic [7:0] CODE_EE = 8'hEE;
  localparam logic [7:0] CODE_FA = 8'hFA;
  localparam logic [7:0] CODE_FE = 8'hFE;
  localparam logic [7:0] CODE_FF = 8'hFF;

  localparam logic [7:0] KEY_LSHIFT = 8'h12;
  localparam logic [7:0] KEY_RSHIFT = 8'h59;
  localparam logic [7:0] KEY_CAPS   = 8'h58;

  // Pause/Break sends E1 followed by seven more bytes that carry no extra information.
  localparam logic [2:0] PAUSE_SKIP_LEN = 3'd7;

  typedef struct packed {
    logic [7:0] key;
    logic       brk;
    logic       ext;
    logic [7:0] ascii;
  } ps2_event_t;

  function automatic logic is_ignored(input logic [7:0] b);
    return (b == CODE_00) || (b == CODE_AA) || (b == CODE_EE) ||
           (b == CODE_FA) || (b == CODE_FE) || (b == CODE_FF);
  endfunction

`ifdef PS2_ASCII_EN
  // Letters resolve to lowercase first; uppercase is derived afterwards from shift XOR caps.
  function automatic logic [7:0] ps2_ascii(input logic [7:0] key, input logic shift,
                                           input logic caps);
    logic [7:0] c;
    c = 8'h00;
    case (key)
      8'h1C: c = 8'h61;
      8'h32: c = 8'h62;
      8'h21: c = 8'h63;
      8'h23: c = 8'h64;
      8'h24: c = 8'h65;
      8'h2B: c = 8'h66;
      8'h34: c = 8'h67;
      8'h33: c = 8'h68;
      8'h43: c = 8'h69;
      8'h3B: c = 8'h6A;
      8'h42: c = 8'h6B;
      8'h4B: c = 8'h6C;
      8'h3A: c = 8'h6D;
      8'h31: c = 8'h6E;
      8'h44: c = 8'h6F;
      8'h4D: c = 8'h70;
      8'h15: c = 8'h71;
      8'h2D: c = 8'h72;
      8'h1B: c = 8'h73;
      8'h2C: c = 8'h74;
      8'h3C: c = 8'h75;
      8'h2A: c = 8'h76;
      8'h1D: c = 8'h77;
      8'h22: c = 8'h78;
      8'h35: c = 8'h79;
      8'h1A: c = 8'h7A;
      8'h45: c = shift ? 8'h29 : 8'h30;
      8'h16: c = shift ? 8'h21 : 8'h31;
      8'h1E: c = shift ? 8'h40 : 8'h32;
      8'h26: c = shift ? 8'h23 : 8'h33;
      8'h25: c = shift ? 8'h24 : 8'h34;
      8'h2E: c = shift ? 8'h25 : 8'h35;
      8'h36: c = shift ? 8'h5E : 8'h36;
      8'h3D: c = shift ? 8'h26 : 8'h37;
      8'h3E: c = shift ? 8'h2A : 8'h38;
      8'h46: c = shift ? 8'h28 : 8'h39;
      8'h29: c = 8'h20;
      8'h5A: c = 8'h0D;
      8'h66: c = 8'h08;
      default: c = 8'h00;
    endcase
    if ((shift ^ caps) && (c >= 8'h61) && (c <= 8'h7A)) c = c - 8'h20;
    return c;
  endfunction
`endif

endpackage

// File: rtl/ps2_event_fifo.sv
// Synchronous FIFO of decoded key events; the caller guarantees push only when room exists
// (or a pop happens on the same edge) and pop only when non-empty.
module ps2_event_fifo
  import ps2_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       push,
  input  ps2_event_t din,
  input  logic       pop,
  output ps2_event_t dout,
  output logic       full,
  output logic       empty
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] PTR_ONE = 1;

  // Pointers carry one extra wrap bit so full and empty can be told apart.
  logic [AW:0] wr_ptr;
  logic [AW:0] rd_ptr;
  ps2_event_t  mem [DEPTH];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else begin
      if (push) begin
        mem[wr_ptr[AW-1:0]] <= din;
        wr_ptr              <= wr_ptr + PTR_ONE;
      end
      if (pop) rd_ptr <= rd_ptr + PTR_ONE;
    end
  end

  assign empty = (wr_ptr == rd_ptr);
  assign full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign dout  = mem[rd_ptr[AW-1:0]];

endmodule

// File: rtl/ps2_scancode_processor.sv
// Folds PS/2 set-2 prefix sequences into key events, tracks shift/caps and queues events.
// Define PS2_ASCII_EN to attach a translated character to each press event.
module ps2_scancode_processor
  import ps2_pkg::*;
#(
  parameter int FIFO_DEPTH = 4
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       code_valid,
  input  logic [7:0] code_in,
  output logic       ev_valid,
  input  logic       ev_ready,
  output logic [7:0] ev_key,
  output logic       ev_break,
  output logic       ev_ext,
  output logic [7:0] ev_ascii,
  output logic       shift,
  output logic       caps,
  output logic       overflow
);

  ps2_state_t state;
  ps2_state_t next_state;
  logic [2:0] skip_cnt;
  logic [2:0] next_skip;

  logic       emit;
  logic       emit_ext;
  logic       emit_brk;
  logic [7:0] emit_key;
  logic [7:0] emit_ascii;

  logic       lshift_held;
  logic       rshift_held;
  logic       caps_held;
  logic       caps_q;

  logic       fifo_full;
  logic       fifo_empty;
  logic       pop;
  logic       push;
  ps2_event_t new_event;
  ps2_event_t head;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= ST_IDLE;
      skip_cnt <= '0;
    end else begin
      state    <= next_state;
      skip_cnt <= next_skip;
    end
  end

  // Ignored bytes abort any prefix or skip sequence before the per-state rules apply.
  always_comb begin
    next_state = state;
    next_skip  = skip_cnt;
    emit       = 1'b0;
    emit_ext   = 1'b0;
    emit_brk   = 1'b0;
    emit_key   = code_in;
    if (code_valid) begin
      if (is_ignored(code_in)) begin
        next_state = ST_IDLE;
        next_skip  = '0;
      end else begin
        case (state)
          ST_IDLE: begin
            if (code_in == CODE_E0) next_state = ST_EXT;
            else if (code_in == CODE_F0) next_state = ST_BRK;
            else if (code_in == CODE_E1) begin
              next_state = ST_SKIP;
              next_skip  = PAUSE_SKIP_LEN;
            end else emit = 1'b1;
          end
          ST_EXT: begin
            if (code_in == CODE_F0) next_state = ST_EXT_BRK;
            else if (code_in != CODE_E0) begin
              emit       = 1'b1;
              emit_ext   = 1'b1;
              next_state = ST_IDLE;
            end
          end
          ST_BRK: begin
            if (code_in == CODE_E0) next_state = ST_EXT_BRK;
            else if (code_in != CODE_F0) begin
              emit       = 1'b1;
              emit_brk   = 1'b1;
              next_state = ST_IDLE;
            end
          end
          ST_EXT_BRK: begin
            if ((code_in != CODE_E0) && (code_in != CODE_F0)) begin
              emit       = 1'b1;
              emit_ext   = 1'b1;
              emit_brk   = 1'b1;
              next_state = ST_IDLE;
            end
          end
          ST_SKIP: begin
            next_skip = skip_cnt - 3'd1;
            if (skip_cnt == 3'd1) begin
              emit       = 1'b1;
              emit_key   = CODE_E1;
              next_state = ST_IDLE;
            end
          end
          default: begin
            next_state = ST_IDLE;
            next_skip  = '0;
          end
        endcase
      end
    end
  end

  // caps_held blocks typematic repeats of the caps key from re-toggling the lock.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      lshift_held <= 1'b0;
      rshift_held <= 1'b0;
      caps_held   <= 1'b0;
      caps_q      <= 1'b0;
    end else if (emit && !emit_ext) begin
      if (emit_key == KEY_LSHIFT) lshift_held <= !emit_brk;
      if (emit_key == KEY_RSHIFT) rshift_held <= !emit_brk;
      if (emit_key == KEY_CAPS) begin
        if (emit_brk) caps_held <= 1'b0;
        else begin
          if (!caps_held) caps_q <= !caps_q;
          caps_held <= 1'b1;
        end
      end
    end
  end

  assign shift = lshift_held | rshift_held;
  assign caps  = caps_q;

`ifdef PS2_ASCII_EN
  assign emit_ascii = (emit_brk || emit_ext) ? 8'h00 : ps2_ascii(emit_key, shift, caps);
`else
  assign emit_ascii = 8'h00;
`endif

  assign new_event = '{key: emit_key, brk: emit_brk, ext: emit_ext, ascii: emit_ascii};
  assign pop       = !fifo_empty && ev_ready;
  assign push      = emit && (!fifo_full || pop);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) overflow <= 1'b0;
    else if (emit && !push) overflow <= 1'b1;
  end

  ps2_event_fifo #(
    .DEPTH(FIFO_DEPTH)
  ) u_fifo (
    .clk  (clk),
    .rst_n(rst_n),
    .push (push),
    .din  (new_event),
    .pop  (pop),
    .dout (head),
    .full (fifo_full),
    .empty(fifo_empty)
  );

  assign ev_valid = !fifo_empty;
  assign ev_key   = head.key;
  assign ev_break = head.brk;
  assign ev_ext   = head.ext;
  assign ev_ascii = head.ascii;

endmodule

// File: tb/tb_ps2_scancode_processor.sv
// Self-checking bench: directed test-plan sequences plus random byte streams compared
// against a flag-based behavioural model with a bounded event queue.
module tb_ps2_scancode_processor;

  localparam int FIFO_DEPTH = 4;

  logic       clk;
  logic       rst_n;
  logic       code_valid;
  logic [7:0] code_in;
  logic       ev_valid;
  logic       ev_ready;
  logic [7:0] ev_key;
  logic       ev_break;
  logic       ev_ext;
  logic [7:0] ev_ascii;
  logic       shift;
  logic       caps;
  logic       overflow;

  ps2_scancode_processor #(
    .FIFO_DEPTH(FIFO_DEPTH)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .code_valid(code_valid),
    .code_in   (code_in),
    .ev_valid  (ev_valid),
    .ev_ready  (ev_ready),
    .ev_key    (ev_key),
    .ev_break  (ev_break),
    .ev_ext    (ev_ext),
    .ev_ascii  (ev_ascii),
    .shift     (shift),
    .caps      (caps),
    .overflow  (overflow)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic [7:0] key;
    logic       brk;
    logic       ext;
    logic [7:0] ascii;
  } exp_ev_t;

  int checks = 0;
  int failures = 0;

  // Reference model state: pending prefix flags, remaining pause bytes, key state, queue.
  logic    m_ext_pend, m_brk_pend;
  int      m_skip;
  logic    m_lshift, m_rshift, m_caps_held, m_caps, m_ovf;
  exp_ev_t mq[$];
  logic [7:0] seq[$];

  logic [7:0] letter_codes [26] = '{8'h1C, 8'h32, 8'h21, 8'h23, 8'h24, 8'h2B, 8'h34, 8'h33,
                                    8'h43, 8'h3B, 8'h42, 8'h4B, 8'h3A, 8'h31, 8'h44, 8'h4D,
                                    8'h15, 8'h2D, 8'h1B, 8'h2C, 8'h3C, 8'h2A, 8'h1D, 8'h22,
                                    8'h35, 8'h1A};
  logic [7:0] digit_codes [10] = '{8'h45, 8'h16, 8'h1E, 8'h26, 8'h25, 8'h2E, 8'h36, 8'h3D,
                                   8'h3E, 8'h46};
  logic [7:0] digit_syms [10] = '{8'h29, 8'h21, 8'h40, 8'h23, 8'h24, 8'h25, 8'h5E, 8'h26,
                                  8'h2A, 8'h28};
  logic [7:0] ignored_codes [6] = '{8'h00, 8'hAA, 8'hEE, 8'hFA, 8'hFE, 8'hFF};

  task automatic checkOutput(input string tag, input logic [7:0] observed,
                             input logic [7:0] expected);
    checks++;
    if (observed !== expected) begin
      failures++;
      $display("[TB] FAIL %s observed=0x%02h expected=0x%02h at %0t", tag, observed, expected,
               $time);
    end
  endtask

  function automatic logic [7:0] modelAscii(input logic [7:0] key, input logic sh,
                                            input logic cp);
    logic [7:0] r;
    r = 8'h00;
`ifdef PS2_ASCII_EN
    for (int i = 0; i < 26; i++)
      if (letter_codes[i] == key) r = ((sh ^ cp) ? 8'h41 : 8'h61) + 8'(i);
    for (int i = 0; i < 10; i++)
      if (digit_codes[i] == key) r = sh ? digit_syms[i] : 8'h30 + 8'(i);
    if (key == 8'h29) r = 8'h20;
    if (key == 8'h5A) r = 8'h0D;
    if (key == 8'h66) r = 8'h08;
`else
    if (sh && cp && key == 8'h00) r = 8'h00;
`endif
    return r;
  endfunction

  function automatic logic modelIgnored(input logic [7:0] b);
    for (int i = 0; i < 6; i++) if (ignored_codes[i] == b) return 1'b1;
    return 1'b0;
  endfunction

  task automatic modelClear();
    m_ext_pend = 0; m_brk_pend = 0; m_skip = 0;
    m_lshift = 0; m_rshift = 0; m_caps_held = 0; m_caps = 0; m_ovf = 0;
    mq.delete();
  endtask

  task automatic modelByte(input logic [7:0] b, output logic have, output exp_ev_t ev);
    have = 0;
    ev   = '0;
    if (modelIgnored(b)) begin
      m_ext_pend = 0; m_brk_pend = 0; m_skip = 0;
    end else if (m_skip > 0) begin
      m_skip--;
      if (m_skip == 0) begin
        have = 1; ev.key = 8'hE1;
      end
    end else if (b == 8'hE0) m_ext_pend = 1;
    else if (b == 8'hF0) m_brk_pend = 1;
    else if (b == 8'hE1 && !m_ext_pend && !m_brk_pend) m_skip = 7;
    else begin
      have = 1; ev.key = b; ev.ext = m_ext_pend; ev.brk = m_brk_pend;
      m_ext_pend = 0; m_brk_pend = 0;
    end
    if (have) begin
      ev.ascii = (ev.brk || ev.ext) ? 8'h00 : modelAscii(ev.key, m_lshift | m_rshift, m_caps);
      if (!ev.ext) begin
        if (ev.key == 8'h12) m_lshift = !ev.brk;
        if (ev.key == 8'h59) m_rshift = !ev.brk;
        if (ev.key == 8'h58) begin
          if (ev.brk) m_caps_held = 0;
          else begin
            if (!m_caps_held) m_caps = !m_caps;
            m_caps_held = 1;
          end
        end
      end
    end
  endtask

  task automatic checkAll();
    checkOutput("ev_valid", {7'd0, ev_valid}, {7'd0, mq.size() != 0});
    if (mq.size() != 0) begin
      checkOutput("ev_key", ev_key, mq[0].key);
      checkOutput("ev_break", {7'd0, ev_break}, {7'd0, mq[0].brk});
      checkOutput("ev_ext", {7'd0, ev_ext}, {7'd0, mq[0].ext});
      checkOutput("ev_ascii", ev_ascii, mq[0].ascii);
    end
    checkOutput("shift", {7'd0, shift}, {7'd0, m_lshift | m_rshift});
    checkOutput("caps", {7'd0, caps}, {7'd0, m_caps});
    checkOutput("overflow", {7'd0, overflow}, {7'd0, m_ovf});
  endtask

  // Called at a falling edge; inputs are sampled on the next rising edge.
  task automatic applyStimulus(input logic v, input logic [7:0] b, input logic rdy);
    logic    have, do_pop;
    exp_ev_t ev;
    code_valid = v;
    code_in    = b;
    ev_ready   = rdy;
    do_pop     = (mq.size() != 0) && rdy;
    have       = 0;
    ev         = '0;
    if (v) modelByte(b, have, ev);
    if (do_pop) void'(mq.pop_front());
    if (have) begin
      if (mq.size() < FIFO_DEPTH) mq.push_back(ev);
      else m_ovf = 1;
    end
    @(posedge clk);
    @(negedge clk);
    checkAll();
  endtask

  task automatic sendSeq(input logic rdy);
    foreach (seq[i]) applyStimulus(1'b1, seq[i], rdy);
  endtask

  task automatic doReset();
    rst_n = 0; code_valid = 0; code_in = 8'h00; ev_ready = 0;
    modelClear();
    @(posedge clk);
    @(negedge clk);
    checkOutput("rst_valid", {7'd0, ev_valid}, 8'h00);
    checkOutput("rst_key", ev_key, 8'h00);
    checkOutput("rst_break", {7'd0, ev_break}, 8'h00);
    checkOutput("rst_ext", {7'd0, ev_ext}, 8'h00);
    checkOutput("rst_ascii", ev_ascii, 8'h00);
    checkOutput("rst_shift", {7'd0, shift}, 8'h00);
    checkOutput("rst_caps", {7'd0, caps}, 8'h00);
    checkOutput("rst_overflow", {7'd0, overflow}, 8'h00);
    rst_n = 1;
  endtask

  initial begin
    logic [7:0] b;
    logic [7:0] tp1_ascii;
    logic [7:0] drain_keys [4];
`ifdef PS2_ASCII_EN
    tp1_ascii = 8'h61;
`else
    tp1_ascii = 8'h00;
`endif
    drain_keys = '{8'h16, 8'h1E, 8'h26, 8'h25};
    rst_n = 0; code_valid = 0; code_in = 8'h00; ev_ready = 0;
    @(negedge clk);
    doReset();

    // Single press, one-cycle latency.
    applyStimulus(1'b1, 8'h1C, 1'b0);
    checkOutput("tp1_valid", {7'd0, ev_valid}, 8'h01);
    checkOutput("tp1_key", ev_key, 8'h1C);
    checkOutput("tp1_ascii", ev_ascii, tp1_ascii);
    applyStimulus(1'b0, 8'h00, 1'b1);
    applyStimulus(1'b0, 8'h00, 1'b1);

    // Shifted letter and releases.
    seq = '{8'h12, 8'h1C, 8'hF0, 8'h1C, 8'hF0, 8'h12};
    sendSeq(1'b1);
    applyStimulus(1'b0, 8'h00, 1'b1);

    // Extended release and pause sequence.
    seq = '{8'hE0, 8'hF0, 8'h75, 8'hE1, 8'h14, 8'h77, 8'hE1, 8'hF0, 8'h14, 8'hF0, 8'h77};
    sendSeq(1'b1);
    applyStimulus(1'b0, 8'h00, 1'b1);

    // Caps toggles once despite repeat; ignored bytes produce nothing.
    seq = '{8'h58, 8'h58, 8'hF0, 8'h58, 8'h1C, 8'hFA, 8'hAA};
    sendSeq(1'b1);
    checkOutput("tp4_caps", {7'd0, caps}, 8'h01);
    applyStimulus(1'b0, 8'h00, 1'b1);

    // Overflow with consumer stalled, then ordered drain.
    doReset();
    seq = '{8'h16, 8'h1E, 8'h26, 8'h25, 8'h2E};
    sendSeq(1'b0);
    checkOutput("tp5_overflow", {7'd0, overflow}, 8'h01);
    for (int i = 0; i < 4; i++) begin
      checkOutput("tp5_drain", ev_key, drain_keys[i]);
      applyStimulus(1'b0, 8'h00, 1'b1);
    end
    checkOutput("tp5_empty", {7'd0, ev_valid}, 8'h00);

    // Reset mid-prefix discards the E0.
    doReset();
    applyStimulus(1'b1, 8'hE0, 1'b0);
    doReset();
    applyStimulus(1'b1, 8'h75, 1'b0);
    checkOutput("tp6_ext", {7'd0, ev_ext}, 8'h00);
    checkOutput("tp6_key", ev_key, 8'h75);
    applyStimulus(1'b0, 8'h00, 1'b1);

    // Random byte streams with random back-pressure.
    for (int round = 0; round < 3; round++) begin
      doReset();
      for (int n = 0; n < 1500; n++) begin
        case ($urandom_range(0, 15))
          0:       b = 8'hE0;
          1, 2:    b = 8'hF0;
          3:       b = ($urandom_range(0, 3) == 0) ? 8'hE1 : 8'h12;
          4:       b = ignored_codes[$urandom_range(0, 5)];
          5:       b = 8'h12;
          6:       b = 8'h59;
          7:       b = 8'h58;
          8, 9, 10: b = letter_codes[$urandom_range(0, 25)];
          11, 12:  b = digit_codes[$urandom_range(0, 9)];
          default: b = 8'($urandom);
        endcase
        applyStimulus($urandom_range(0, 3) != 0, b,
                      (round == 2) ? ($urandom_range(0, 3) == 0) : ($urandom_range(0, 2) != 0));
      end
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/ps2_scancode_processor.md
# ps2_scancode_processor

Downstream consumer of the PS/2 frame receiver. It takes each received scan-code-set-2 byte and its one-cycle strobe, folds the E0/F0/E1 prefix sequences into single key events, and tracks shift and caps-lock state. Completed events go into a small FIFO, which the host logic (display, UART bridge) drains through a valid/ready handshake.

## Interface
- FIFO_DEPTH, 4, event FIFO entries; power of two, ≥2
- clk  in  1  clock
- rst_n  in  1  reset; asynchronous, active-low
- code_valid  in  1  one-cycle strobe: code_in holds a new received byte; may assert every cycle
- code_in  in  8  received scan-code byte
- ev_valid  out  1  FIFO head holds an event
- ev_ready  in  1  consumer accepts the head event
- ev_key  out  8  final (non-prefix) scan-code byte of the event
- ev_break  out  1  1 = key release, 0 = key press
- ev_ext  out  1  1 = E0-prefixed key
- ev_ascii  out  8  translated character; 0 if none
- shift  out  1  live state: left shift (0x12) or right shift (0x59) held
- caps  out  1  caps-lock toggle state
- overflow  out  1  sticky: an event was dropped because the FIFO was full

## Operation
- All outputs reset to 0. On reset: FSM to IDLE, FIFO empty, held-key bits cleared, skip counter cleared.
- Ignored bytes are 0x00, 0xAA, 0xEE, 0xFA, 0xFE and 0xFF. Any of them is discarded and the FSM goes to IDLE.
- Byte handling, evaluated only when code_valid=1:
  - IDLE: E0→EXT; F0→BRK; E1→SKIP with skip count 7; any other byte emits {ext=0, brk=0} and stays in IDLE.
  - EXT: F0→EXT_BRK; E0 stays in EXT; any other byte emits {ext=1, brk=0} and goes to IDLE.
  - BRK: E0→EXT_BRK; F0 stays in BRK; any other byte emits {ext=0, brk=1} and goes to IDLE.
  - EXT_BRK: E0 or F0 stays in EXT_BRK; any other byte emits {ext=1, brk=1} and goes to IDLE.
  - SKIP: each byte decrements the count. The byte that brings the count to 0 emits {key=0xE1, ext=0, brk=0} and goes to IDLE. Pause/Break therefore yields exactly one event.
- Held-key tracking applies to non-extended events only:
  - 0x12 press sets lshift_held; release clears it. 0x59 works the same way for rshift_held.
  - 0x58 press toggles caps only if caps_held=0, then sets caps_held. This suppresses typematic repeats. Release of 0x58 clears caps_held.
- shift, caps and the held bits update on the same edge as the push.
- ASCII is computed from shift/caps before that update.
- Shift-key and caps-key events are still emitted as events.
- FIFO behaviour:
  - ev_valid = !empty. ev_key, ev_break, ev_ext and ev_ascii show the head entry.
  - A pop happens when ev_valid && ev_ready.
  - A push is accepted when the FIFO is not full, or when it is full and a pop happens on the same edge.
  - Otherwise the event is dropped and overflow is set to 1. Only reset clears overflow.
- Asserting rst_n mid-sequence discards any partially received prefix and skip state.

## Timing
- A byte is consumed on the clk edge where code_valid=1.
- With the FIFO empty, the event is visible (ev_valid=1) on the cycle after the strobe. The event path therefore has 1-cycle latency.
- Head outputs remain stable while ev_valid=1 && ev_ready=0.
- shift and caps change on the cycle after the strobe of the triggering byte.
- FIFO throughput is one push and one pop per cycle. A simultaneous push and pop at empty is legal: the new entry appears the next cycle.

## Configuration
- PS2_ASCII_EN defined:
  - Mapping applies to press events with ext=0; releases, extended keys and unmapped codes give 0.
  - Letters a–z map to 0x61–0x7A, or 0x41–0x5A when shift XOR caps.
  - Digits 0–9 map to 0x30–0x39. With shift they map to the US symbols ")!@#$%^&*(".
  - 0x29 maps to 0x20, 0x5A to 0x0D, 0x66 to 0x08.
- PS2_ASCII_EN undefined: no lookup logic; ev_ascii is constant 0. Caps and shift tracking are unchanged.

## Structure
- Package ps2_pkg contains:
  - the FSM state enum;
  - prefix and ignored-byte constants (E0, F0, E1, AA, FA, …);
  - the event struct typedef {key, brk, ext, ascii};
  - the ASCII lookup function, guarded by PS2_ASCII_EN.
- Sub-module ps2_event_fifo: a parameterised synchronous FIFO of event structs with full/empty flags.

## Test plan
- 0x1C → single event key=0x1C, brk=0, ext=0, ascii=0x61 (0x00 without the macro); ev_valid rises 1 cycle after the strobe.
- 0x12, 0x1C, F0 1C, F0 12 → four events: 12 press; 1C press with ascii=0x41; 1C release with ascii=0; 12 release. shift is 1 between the first and last events, then 0.
- E0 F0 75 → exactly one event key=0x75, ext=1, brk=1. E1 14 77 E1 F0 14 F0 77 → exactly one event key=0xE1.
- 0x58, 0x58, F0 58, 0x1C → caps=1 (single toggle), last event ascii=0x41. Then 0xFA and 0xAA produce no events.
- ev_ready=0, FIFO_DEPTH=4, five presses 0x16/0x1E/0x26/0x25/0x2E → four held, overflow=1, fifth dropped. Raising ev_ready drains 16, 1E, 26, 25 in order.
- E0, then rst_n pulsed low, then 0x75 → event ext=0; all outputs read 0 during reset.
